// File: rtl/uart_tx_feeder.sv
// Byte FIFO with single-cycle flush, used to queue bytes ahead of the UART transmitter.
// Latency: a pushed byte is visible on rd_dat/rd_vld the cycle after the push.
// Backpressure: wr_rdy drops at DEPTH entries; a same-cycle pop never frees room for a push.
module sync_fifo #(
    parameter int  DEPTH = 16,
    parameter int  W     = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat,
    output logic [AW:0]  count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push;
    logic          pop;

    assign wr_rdy = (count_q != FULL_CNT);
    assign rd_vld = (count_q != '0);
    assign rd_dat = mem_q[rd_ptr_q];
    assign count  = count_q;

    // Flush wins over both ports, so neither pointer nor storage moves that cycle.
    assign push = wr_vld && wr_rdy && !flush;
    assign pop  = rd_rdy && rd_vld && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_dat;
    end
endmodule

// Feeds queued bytes one at a time into a UART transmitter via send/dintx/donetx.
// Latency: a write into an idle, empty feeder raises send two cycles later.
// Backpressure: writes beyond DEPTH are dropped and flagged; a stuck transmitter is abandoned by a watchdog.
module uart_tx_feeder #(
    parameter int  clk_freq  = 1000000,
    parameter int  baud_rate = 9600,
    parameter int  DEPTH     = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        flush,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output logic        busy,
    output logic        ovf_err,
    output logic        timeout_err,
    output logic        send,
    output logic [7:0]  dintx,
    input  logic        donetx
);
    localparam int TMO_RAW = 12 * clk_freq / baud_rate;
    localparam int TMO     = (TMO_RAW < 2) ? 2 : TMO_RAW;
    localparam int WDW     = $clog2(TMO + 1);
    // The counter is 0 in the first WAIT cycle, so the limit is hit one count early.
    localparam logic [WDW-1:0] WD_LAST = WDW'(TMO - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     dintx_q, dintx_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           ovf_q, ovf_d;
    logic           tmo_q, tmo_d;

    logic           fifo_wr_rdy;
    logic           fifo_rd_vld;
    logic           fifo_pop;
    logic [7:0]     fifo_rd_dat;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .wr_vld (wr_en),
        .wr_dat (wr_data),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (fifo_rd_vld),
        .rd_rdy (fifo_pop),
        .rd_dat (fifo_rd_dat),
        .count  (count)
    );

    assign full        = !fifo_wr_rdy;
    assign empty       = !fifo_rd_vld;
    assign busy        = (state_q != ST_IDLE);
    assign send        = (state_q == ST_SEND);
    assign dintx       = dintx_q;
    assign ovf_err     = ovf_q;
    assign timeout_err = tmo_q;

    always_comb begin
        state_d  = state_q;
        dintx_d  = dintx_q;
        wdog_d   = wdog_q;
        ovf_d    = ovf_q;
        tmo_d    = tmo_q;
        fifo_pop = 1'b0;

        if (flush) begin
            ovf_d = 1'b0;
            tmo_d = 1'b0;
        end
        if (wr_en && !flush && !fifo_wr_rdy) ovf_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (fifo_rd_vld && !flush) begin
                    fifo_pop = 1'b1;
                    dintx_d  = fifo_rd_dat;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (donetx) begin
                    state_d = ST_IDLE;
                end else if (wdog_q == WD_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            dintx_q <= 8'h00;
            wdog_q  <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dintx_q <= dintx_d;
            wdog_q  <= wdog_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed scenarios plus randomized byte streams checked against a schedule model.
module tb_uart_tx_feeder;
    localparam int DEPTH = 16;
    localparam int TMO   = 12 * 1000000 / 9600;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       donetx = 1'b0;
    logic       full, empty, busy, ovf_err, timeout_err, send;
    logic [4:0] count;
    logic [7:0] dintx;

    int n_checks = 0;
    int n_fail   = 0;

    int         s_wr  [16];
    logic [7:0] s_dat [16];
    int         s_dly [16];

    uart_tx_feeder #(
        .clk_freq  (1000000),
        .baud_rate (9600),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .flush       (flush),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .busy        (busy),
        .ovf_err     (ovf_err),
        .timeout_err (timeout_err),
        .send        (send),
        .dintx       (dintx),
        .donetx      (donetx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        n_checks++; if (send !== 1'b0) begin n_fail++; $display("FAIL reset_send: got %b expected 0", send); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (dintx !== 8'h00) begin n_fail++; $display("FAIL reset_dintx: got %h expected 00", dintx); end
        n_checks++; if ({full, empty} !== 2'b01) begin n_fail++; $display("FAIL reset_full_empty: got %b expected 01", {full, empty}); end
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if ({ovf_err, timeout_err} !== 2'b00) begin n_fail++; $display("FAIL reset_errs: got %b expected 00", {ovf_err, timeout_err}); end
        step(); step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_byte();
        wr_en = 1'b1; wr_data = 8'hA5; step(); wr_en = 1'b0;
        n_checks++; if ({count, send} !== {5'd1, 1'b0}) begin n_fail++; $display("FAIL single_c1: got count=%0d send=%b expected 1,0", count, send); end
        step();
        n_checks++; if ({send, busy} !== 2'b11) begin n_fail++; $display("FAIL single_send: got send=%b busy=%b expected 1,1", send, busy); end
        n_checks++; if (dintx !== 8'hA5) begin n_fail++; $display("FAIL single_dintx: got %h expected a5", dintx); end
        step();
        n_checks++; if ({send, busy} !== 2'b01) begin n_fail++; $display("FAIL single_pulse: got send=%b busy=%b expected 0,1", send, busy); end
        repeat (4) step();
        donetx = 1'b1; step(); donetx = 1'b0;
        n_checks++; if ({busy, empty} !== 2'b01) begin n_fail++; $display("FAIL single_done: got busy=%b empty=%b expected 0,1", busy, empty); end
        n_checks++; if (dintx !== 8'hA5) begin n_fail++; $display("FAIL single_hold: got %h expected a5", dintx); end
        donetx = 1'b1; step(); donetx = 1'b0; step();
        n_checks++; if ({busy, send} !== 2'b00) begin n_fail++; $display("FAIL idle_donetx: got busy=%b send=%b expected 0,0", busy, send); end
    endtask

    // Expected schedule: byte k goes out at max(write+2, previous donetx+2); donetx arrives dly cycles after send.
    task automatic run_stream(input string name, input int n);
        int s_snd [16];
        int s_done [16];
        int last_done, total, nw, ns;
        bit exp_wr, exp_dn, exp_send, exp_busy;
        logic [7:0] exp_dat, wdat;
        last_done = -100;
        for (int k = 0; k < n; k++) begin
            s_snd[k]  = (s_wr[k] + 2 > last_done + 2) ? s_wr[k] + 2 : last_done + 2;
            s_done[k] = s_snd[k] + s_dly[k];
            last_done = s_done[k];
        end
        total = last_done + 4;
        for (int c = 0; c < total; c++) begin
            exp_wr = 0; exp_dn = 0; exp_send = 0; exp_busy = 0;
            nw = 0; ns = 0; wdat = 8'h00; exp_dat = 8'h00;
            for (int k = 0; k < n; k++) begin
                if (s_wr[k] == c) begin exp_wr = 1; wdat = s_dat[k]; end
                if (s_done[k] == c) exp_dn = 1;
                if (s_snd[k] == c) begin exp_send = 1; exp_dat = s_dat[k]; end
                if (s_snd[k] <= c && c <= s_done[k]) exp_busy = 1;
                if (s_wr[k] < c) nw++;
                if (s_snd[k] <= c) ns++;
            end
            wr_en = exp_wr; wr_data = wdat; donetx = exp_dn;
            n_checks++; if (send !== exp_send) begin n_fail++; $display("FAIL %s_send c=%0d: got %b expected %b", name, c, send, exp_send); end
            if (exp_send) begin
                n_checks++; if (dintx !== exp_dat) begin n_fail++; $display("FAIL %s_dintx c=%0d: got %h expected %h", name, c, dintx, exp_dat); end
            end
            n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL %s_busy c=%0d: got %b expected %b", name, c, busy, exp_busy); end
            n_checks++; if (count !== 5'(nw - ns)) begin n_fail++; $display("FAIL %s_count c=%0d: got %0d expected %0d", name, c, count, nw - ns); end
            n_checks++; if (empty !== (nw == ns)) begin n_fail++; $display("FAIL %s_empty c=%0d: got %b expected %b", name, c, empty, (nw == ns)); end
            step();
        end
        wr_en = 1'b0; donetx = 1'b0;
        n_checks++; if ({ovf_err, timeout_err} !== 2'b00) begin n_fail++; $display("FAIL %s_errs: got %b expected 00", name, {ovf_err, timeout_err}); end
    endtask

    task automatic test_burst();
        for (int k = 0; k < 4; k++) begin
            s_wr[k] = k; s_dat[k] = 8'(k + 1); s_dly[k] = 20;
        end
        run_stream("burst", 4);
    endtask

    task automatic test_random_stream();
        s_wr[0] = int'($urandom_range(0, 5));
        for (int k = 0; k < 12; k++) begin
            if (k > 0) s_wr[k] = s_wr[k-1] + 1 + int'($urandom_range(0, 25));
            s_dat[k] = 8'($urandom);
            s_dly[k] = int'($urandom_range(1, 30));
        end
        run_stream("random", 12);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 12; k++) begin
            s_wr[k] = k; s_dat[k] = 8'($urandom); s_dly[k] = int'($urandom_range(1, 6));
        end
        run_stream("b2b", 12);
    endtask

    task automatic test_overflow();
        wr_en = 1'b1; wr_data = 8'hEE; step(); wr_en = 1'b0;
        repeat (3) step();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); step();
        end
        wr_en = 1'b0;
        n_checks++; if ({full, count} !== {1'b1, 5'd16}) begin n_fail++; $display("FAIL ovf_full: got full=%b count=%0d expected 1,16", full, count); end
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", ovf_err); end
        wr_en = 1'b1; wr_data = 8'h77; step(); wr_en = 1'b0;
        n_checks++; if ({ovf_err, count} !== {1'b1, 5'd16}) begin n_fail++; $display("FAIL ovf_drop: got ovf=%b count=%0d expected 1,16", ovf_err, count); end
        flush = 1'b1; step(); flush = 1'b0;
        n_checks++; if ({count, ovf_err, empty} !== {5'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL ovf_flush: got count=%0d ovf=%b empty=%b expected 0,0,1", count, ovf_err, empty); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_inflight: got busy=%b expected 1", busy); end
        wr_en = 1'b1; flush = 1'b1; wr_data = 8'h55; step(); wr_en = 1'b0; flush = 1'b0;
        n_checks++; if ({count, ovf_err} !== {5'd0, 1'b0}) begin n_fail++; $display("FAIL wr_flush: got count=%0d ovf=%b expected 0,0", count, ovf_err); end
        donetx = 1'b1; step(); donetx = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovf_idle: got busy=%b expected 0", busy); end
        step(); step();
        n_checks++; if ({send, busy, dintx} !== {2'b00, 8'hEE}) begin n_fail++; $display("FAIL ovf_nosend: got send=%b busy=%b dintx=%h expected 0,0,ee", send, busy, dintx); end
    endtask

    task automatic test_full_pop();
        wr_en = 1'b1; wr_data = 8'hC0; step(); wr_en = 1'b0;
        repeat (3) step();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hD0 + i); step();
        end
        wr_en = 1'b0;
        donetx = 1'b1; step(); donetx = 1'b0;
        wr_en = 1'b1; wr_data = 8'h99; step(); wr_en = 1'b0;
        n_checks++; if ({send, dintx} !== {1'b1, 8'hD0}) begin n_fail++; $display("FAIL fullpop_send: got send=%b dintx=%h expected 1,d0", send, dintx); end
        n_checks++; if ({count, ovf_err, full} !== {5'd15, 1'b1, 1'b0}) begin n_fail++; $display("FAIL fullpop_count: got count=%0d ovf=%b full=%b expected 15,1,0", count, ovf_err, full); end
        step(); step();
        donetx = 1'b1; step(); donetx = 1'b0;
        flush = 1'b1; step(); flush = 1'b0;
        n_checks++; if ({busy, send, count, ovf_err} !== {2'b00, 5'd0, 1'b0}) begin n_fail++; $display("FAIL idle_flush: got busy=%b send=%b count=%0d ovf=%b expected 0,0,0,0", busy, send, count, ovf_err); end
        step();
        n_checks++; if ({busy, send} !== 2'b00) begin n_fail++; $display("FAIL idle_flush_after: got busy=%b send=%b expected 0,0", busy, send); end
    endtask

    task automatic test_watchdog();
        wr_en = 1'b1; wr_data = 8'hB1; step(); wr_data = 8'hB2; step(); wr_en = 1'b0;
        n_checks++; if ({send, dintx} !== {1'b1, 8'hB1}) begin n_fail++; $display("FAIL wd_send1: got send=%b dintx=%h expected 1,b1", send, dintx); end
        repeat (TMO - 1) step();
        n_checks++; if ({timeout_err, busy} !== 2'b01) begin n_fail++; $display("FAIL wd_early: got tmo=%b busy=%b expected 0,1", timeout_err, busy); end
        step();
        n_checks++; if ({timeout_err, busy, count} !== {2'b10, 5'd1}) begin n_fail++; $display("FAIL wd_fire: got tmo=%b busy=%b count=%0d expected 1,0,1", timeout_err, busy, count); end
        step();
        n_checks++; if ({send, dintx, count, timeout_err} !== {1'b1, 8'hB2, 5'd0, 1'b1}) begin n_fail++; $display("FAIL wd_next: got send=%b dintx=%h count=%0d tmo=%b expected 1,b2,0,1", send, dintx, count, timeout_err); end
        step();
        donetx = 1'b1; step(); donetx = 1'b0;
        flush = 1'b1; step(); flush = 1'b0;
        n_checks++; if ({timeout_err, busy} !== 2'b00) begin n_fail++; $display("FAIL wd_clear: got tmo=%b busy=%b expected 0,0", timeout_err, busy); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h30 + i); step();
        end
        wr_en = 1'b0;
        n_checks++; if ({count, busy} !== {5'd3, 1'b1}) begin n_fail++; $display("FAIL rmid_pre: got count=%0d busy=%b expected 3,1", count, busy); end
        step();
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({send, busy, count, dintx, empty} !== {2'b00, 5'd0, 8'h00, 1'b1}) begin n_fail++; $display("FAIL rmid_async: got send=%b busy=%b count=%0d dintx=%h empty=%b expected 0,0,0,00,1", send, busy, count, dintx, empty); end
        step(); step();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (send !== 1'b0 || count !== 5'd0) seen = 1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet: got activity=%b expected 0", seen); end
        wr_en = 1'b1; wr_data = 8'h5A; step(); wr_en = 1'b0; step();
        n_checks++; if ({send, dintx} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL rmid_resume: got send=%b dintx=%h expected 1,5a", send, dintx); end
        step(); donetx = 1'b1; step(); donetx = 1'b0; step();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_back_to_back();
        test_random_stream();
        test_overflow();
        test_full_pop();
        test_watchdog();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no completion expected finish before 1000000");
        $fatal(1, "simulation time limit");
    end
endmodule
